// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bus for bit_serializer: parallel valid/ready input side
// plus the serial stream and status outputs.
interface bit_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              ser_out;
    logic              ser_valid;
    logic              word_done;
    logic              busy;

    modport master (
        output din, din_valid,
        input  din_ready, ser_out, ser_valid, word_done, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, ser_out, ser_valid, word_done, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder with a one-word holding register for gapless streaming.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
module bit_serializer #(
    parameter int   DATA_W    = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    bit_serializer_if.slave bus
);

`ifdef SER_PARITY_EN
    localparam int LEN = DATA_W + 1;
`else
    localparam int LEN = DATA_W;
`endif
    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ser_out_q, ser_out_d;
    logic              ser_valid_q, ser_valid_d;
    logic              word_done_q, word_done_d;

    logic last_bit;
    logic load_now;
    logic accept;
    logic data_bit;
    logic cur_bit;

    assign last_bit      = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign load_now      = hold_full_q && ((state_q == IDLE) || last_bit);
    assign bus.din_ready = rst_n && (!hold_full_q || load_now);
    assign accept        = bus.din_valid && bus.din_ready;
    assign data_bit      = MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0];

`ifdef SER_PARITY_EN
    logic par_q, par_d;
    // Once all data bits have shifted out, the final slot carries the parity captured at load.
    assign cur_bit = (cnt_q == CNT_W'(DATA_W)) ? par_q : data_bit;
`else
    assign cur_bit = data_bit;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        word_done_d = 1'b0;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif

        // Reading hold out and writing a new word can share one edge; the write wins.
        if (load_now) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load_now) begin
                    sreg_d  = hold_q;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SER_PARITY_EN
                    par_d   = ^hold_q;
`endif
                end
            end
            SHIFT: begin
                ser_out_d   = cur_bit;
                ser_valid_d = 1'b1;
                word_done_d = last_bit;
                sreg_d      = MSB_FIRST ? {sreg_q[DATA_W-2:0], 1'b0}
                                        : {1'b0, sreg_q[DATA_W-1:1]};
                cnt_d       = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    if (load_now) begin
                        sreg_d = hold_q;
                        cnt_d  = '0;
`ifdef SER_PARITY_EN
                        par_d  = ^hold_q;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sreg_q      <= '0;
            cnt_q       <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.word_done = word_done_q;
    assign bus.busy      = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: expected bits are queued at each accepted word
// and popped as ser_valid bits appear. Honors SER_PARITY_EN.
`timescale 1ns/1ps
module tb_bit_serializer;

    localparam int DATA_W = 8;
`ifdef SER_PARITY_EN
    localparam int LEN = DATA_W + 1;
`else
    localparam int LEN = DATA_W;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bit_serializer_if #(.DATA_W(DATA_W)) bus_m ();
    bit_serializer_if #(.DATA_W(DATA_W)) bus_l ();

    bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_m)
    );

    bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_l)
    );

    // Expected serial image of one word, including the parity slot when enabled.
    task automatic push_word(input logic [DATA_W-1:0] w, input bit msb);
        exp_t e;
        for (int i = 0; i < DATA_W; i++) begin
            e.b    = msb ? w[DATA_W-1-i] : w[i];
            e.last = (i == LEN - 1);
            exp_q.push_back(e);
        end
`ifdef SER_PARITY_EN
        e.b    = ^w;
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus_m.din       = 8'hFF;
        bus_m.din_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_m.din_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b required 0", bus_m.din_ready);
        end
        n_checks++;
        if (bus_m.ser_out !== 1'b0 || bus_m.ser_valid !== 1'b0 || bus_m.word_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got ser_out=%b ser_valid=%b word_done=%b required 0/0/0",
                               bus_m.ser_out, bus_m.ser_valid, bus_m.word_done);
        end
        n_checks++;
        if (bus_m.busy !== 1'b0 || bus_l.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b/%b required 0/0", bus_m.busy, bus_l.busy);
        end
        bus_m.din_valid = 1'b0;
        bus_m.din       = '0;
        rst_n           = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_m.din_ready !== 1'b1 || bus_l.din_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b/%b required 1/1", bus_m.din_ready, bus_l.din_ready);
        end
        n_checks++;
        if (bus_m.busy !== 1'b0 || bus_m.ser_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_idle: got busy=%b ser_valid=%b required 0/0", bus_m.busy, bus_m.ser_valid);
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   first_v = -1, nvalid = 0, ndone = 0, done_c = -1;
        exp_q.delete();
        bus_m.din       = 8'h92;
        bus_m.din_valid = 1'b1;
        n_checks++;
        if (bus_m.din_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready: got %b required 1", bus_m.din_ready);
        end
        push_word(8'h92, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus_m.din_valid = 1'b0;
            bus_m.din       = '0;
            if (bus_m.ser_valid === 1'b1) begin
                nvalid++;
                if (first_v < 0) first_v = c;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL single_bit: got extra bit %b required none", bus_m.ser_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_m.ser_out !== e.b || bus_m.word_done !== e.last) begin
                        n_fail++; $display("FAIL single_bit c%0d: got %b/%b required %b/%b",
                                           c, bus_m.ser_out, bus_m.word_done, e.b, e.last);
                    end
                end
            end else begin
                n_checks++;
                if (bus_m.ser_out !== 1'b0 || bus_m.word_done !== 1'b0) begin
                    n_fail++; $display("FAIL single_idle c%0d: got ser_out=%b word_done=%b required 0/0",
                                       c, bus_m.ser_out, bus_m.word_done);
                end
            end
            if (bus_m.word_done === 1'b1) begin
                ndone++;
                done_c = c;
            end
        end
        n_checks++;
        if (first_v != 3) begin
            n_fail++; $display("FAIL single_latency: got first bit at cycle %0d required 3", first_v);
        end
        n_checks++;
        if (nvalid != LEN || ndone != 1) begin
            n_fail++; $display("FAIL single_counts: got valid=%0d done=%0d required %0d/1", nvalid, ndone, LEN);
        end
        n_checks++;
        if (done_c != first_v + LEN - 1) begin
            n_fail++; $display("FAIL single_done_pos: got %0d required %0d", done_c, first_v + LEN - 1);
        end
        n_checks++;
        if (exp_q.size() != 0 || bus_m.busy !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got pending=%0d busy=%b required 0/0", exp_q.size(), bus_m.busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [7:0]  words [2] = '{8'h92, 8'h49};
        int          acc [2]   = '{-1, -1};
        int          done_q[$];
        int          idx = 0, first_v = -1, last_v = -1, nvalid = 0;
        bit          pend;
        exp_q.delete();
        bus_m.din       = words[0];
        bus_m.din_valid = 1'b1;
        pend = bus_m.din_ready;
        if (pend) begin
            push_word(words[0], 1'b1);
            acc[0] = 0;
        end
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus_m.ser_valid === 1'b1) begin
                nvalid++;
                if (first_v < 0) first_v = c;
                last_v = c;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_bit: got extra bit %b required none", bus_m.ser_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_m.ser_out !== e.b || bus_m.word_done !== e.last) begin
                        n_fail++; $display("FAIL b2b_bit c%0d: got %b/%b required %b/%b",
                                           c, bus_m.ser_out, bus_m.word_done, e.b, e.last);
                    end
                end
            end
            if (bus_m.word_done === 1'b1) done_q.push_back(c);
            if (pend) idx++;
            if (idx < 2) begin
                bus_m.din       = words[idx];
                bus_m.din_valid = 1'b1;
            end else begin
                bus_m.din       = '0;
                bus_m.din_valid = 1'b0;
            end
            pend = bus_m.din_valid && bus_m.din_ready;
            if (pend) begin
                push_word(words[idx], 1'b1);
                acc[idx] = c;
            end
        end
        n_checks++;
        if (nvalid != 2 * LEN || last_v - first_v + 1 != 2 * LEN) begin
            n_fail++; $display("FAIL b2b_contiguous: got valid=%0d span=%0d required %0d/%0d",
                               nvalid, last_v - first_v + 1, 2 * LEN, 2 * LEN);
        end
        n_checks++;
        if (done_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_done_count: got %0d required 2", done_q.size());
        end else if (done_q[1] - done_q[0] != LEN) begin
            n_fail++; $display("FAIL b2b_done_count: got spacing %0d required %0d", done_q[1] - done_q[0], LEN);
        end
        n_checks++;
        if (acc[1] < 0 || done_q.size() == 0 || acc[1] >= done_q[0]) begin
            n_fail++; $display("FAIL b2b_early_accept: got second accept at %0d required before first word_done", acc[1]);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: got %0d pending bits required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t       e;
        logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'hE1};
        int         idx = 0, nvalid = 0, ndone = 0, stalls = 0, rises = 0;
        bit         pend, prev_ready, rise_prev;
        exp_q.delete();
        bus_m.din       = words[0];
        bus_m.din_valid = 1'b1;
        prev_ready = bus_m.din_ready;
        rise_prev  = 1'b0;
        pend = bus_m.din_ready;
        if (pend) push_word(words[0], 1'b1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus_m.ser_valid === 1'b1) begin
                nvalid++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_bit: got extra bit %b required none", bus_m.ser_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_m.ser_out !== e.b || bus_m.word_done !== e.last) begin
                        n_fail++; $display("FAIL bp_bit c%0d: got %b/%b required %b/%b",
                                           c, bus_m.ser_out, bus_m.word_done, e.b, e.last);
                    end
                end
            end
            if (bus_m.word_done === 1'b1) ndone++;
            // A ready that reopens after a stall must coincide with the last_bit cycle.
            if (rise_prev) begin
                n_checks++;
                if (bus_m.word_done !== 1'b1) begin
                    n_fail++; $display("FAIL bp_ready_reopen c%0d: got word_done=%b next cycle required 1",
                                       c, bus_m.word_done);
                end
            end
            if (pend) idx++;
            if (idx < 3) begin
                bus_m.din       = words[idx];
                bus_m.din_valid = 1'b1;
            end else begin
                bus_m.din       = '0;
                bus_m.din_valid = 1'b0;
            end
            rise_prev = bus_m.din_valid && bus_m.din_ready && !prev_ready;
            if (rise_prev) rises++;
            if (bus_m.din_valid && !bus_m.din_ready) stalls++;
            prev_ready = bus_m.din_ready;
            pend = bus_m.din_valid && bus_m.din_ready;
            if (pend) push_word(words[idx], 1'b1);
        end
        n_checks++;
        if (stalls != LEN - 1 || rises != 1) begin
            n_fail++; $display("FAIL bp_stall: got stalls=%0d rises=%0d required %0d/1", stalls, rises, LEN - 1);
        end
        n_checks++;
        if (idx != 3 || nvalid != 3 * LEN || ndone != 3) begin
            n_fail++; $display("FAIL bp_words: got accepted=%0d valid=%0d done=%0d required 3/%0d/3",
                               idx, nvalid, ndone, 3 * LEN);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_drain: got %0d pending bits required 0", exp_q.size());
        end
    endtask

    task automatic test_lsb_first();
        exp_t e;
        int   first_v = -1, nvalid = 0, ndone = 0;
        exp_q.delete();
        bus_l.din       = 8'h01;
        bus_l.din_valid = 1'b1;
        n_checks++;
        if (bus_l.din_ready !== 1'b1) begin
            n_fail++; $display("FAIL lsb_ready: got %b required 1", bus_l.din_ready);
        end
        push_word(8'h01, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus_l.din_valid = 1'b0;
            bus_l.din       = '0;
            if (bus_l.ser_valid === 1'b1) begin
                nvalid++;
                if (first_v < 0) first_v = c;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL lsb_bit: got extra bit %b required none", bus_l.ser_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_l.ser_out !== e.b || bus_l.word_done !== e.last) begin
                        n_fail++; $display("FAIL lsb_bit c%0d: got %b/%b required %b/%b",
                                           c, bus_l.ser_out, bus_l.word_done, e.b, e.last);
                    end
                end
            end
            if (bus_l.word_done === 1'b1) ndone++;
        end
        n_checks++;
        if (first_v != 3 || nvalid != LEN || ndone != 1 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL lsb_summary: got first=%0d valid=%0d done=%0d pending=%0d required 3/%0d/1/0",
                               first_v, nvalid, ndone, exp_q.size(), LEN);
        end
    endtask

    task automatic test_reset_mid_word();
        exp_t e;
        int   nvalid = 0, first_v = -1, ndone = 0;
        bit   hit = 1'b0;
        exp_q.delete();
        bus_m.din       = 8'hFF;
        bus_m.din_valid = 1'b1;
        for (int c = 1; c <= 20 && !hit; c++) begin
            @(negedge clk);
            bus_m.din_valid = 1'b0;
            bus_m.din       = '0;
            if (bus_m.ser_valid === 1'b1) nvalid++;
            if (nvalid == 4) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++; $display("FAIL midrst_reach: got %0d bits required 4 before reset", nvalid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_m.ser_out !== 1'b0 || bus_m.ser_valid !== 1'b0 || bus_m.busy !== 1'b0 || bus_m.word_done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: got ser_out=%b valid=%b busy=%b done=%b required 0/0/0/0",
                               bus_m.ser_out, bus_m.ser_valid, bus_m.busy, bus_m.word_done);
        end
        n_checks++;
        if (bus_m.din_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ready: got %b required 0", bus_m.din_ready);
        end
        rst_n           = 1'b1;
        bus_m.din       = 8'h92;
        bus_m.din_valid = 1'b1;
        push_word(8'h92, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus_m.din_valid = 1'b0;
            bus_m.din       = '0;
            if (bus_m.ser_valid === 1'b1) begin
                if (first_v < 0) first_v = c;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL midrst_bit: got extra bit %b required none", bus_m.ser_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_m.ser_out !== e.b || bus_m.word_done !== e.last) begin
                        n_fail++; $display("FAIL midrst_bit c%0d: got %b/%b required %b/%b",
                                           c, bus_m.ser_out, bus_m.word_done, e.b, e.last);
                    end
                end
            end else begin
                n_checks++;
                if (bus_m.word_done !== 1'b0 || bus_m.ser_out !== 1'b0) begin
                    n_fail++; $display("FAIL midrst_idle c%0d: got done=%b ser_out=%b required 0/0",
                                       c, bus_m.word_done, bus_m.ser_out);
                end
            end
            if (bus_m.word_done === 1'b1) ndone++;
        end
        n_checks++;
        if (first_v != 3 || ndone != 1 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL midrst_recover: got first=%0d done=%0d pending=%0d required 3/1/0",
                               first_v, ndone, exp_q.size());
        end
    endtask

    initial begin
        bus_m.din       = '0;
        bus_m.din_valid = 1'b0;
        bus_l.din       = '0;
        bus_l.din_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_lsb_first();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation time limit required completion");
        $fatal(1);
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial feeder stage placed directly upstream of the 10010 sequence detectors.
- Accepts DATA_W-bit words over a valid/ready handshake.
- Emits the words one bit per clock on ser_out, which drives the detector's data_in.
- A one-word holding register allows gapless back-to-back streaming; between words the line sits at a fixed idle level.

Parameters:
- DATA_W, 8, word width in bits (DATA_W >= 2).
- MSB_FIRST, 1, 1: bit DATA_W-1 is sent first; 0: bit 0 is sent first.
- IDLE_BIT, 1'b0, level driven on ser_out whenever no bit is being shifted.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- din  input  DATA_W  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept din this cycle.
- ser_out  output  1  serial bit stream, registered; connects to the detector data_in.
- ser_valid  output  1  high while ser_out carries a data (or parity) bit.
- word_done  output  1  one-cycle pulse, coincident with the last bit of a word on ser_out.
- busy  output  1  high when the shifter is active or the holding register is full.

Behaviour:
- Reset: rst_n low at a clock edge sets:
  - ser_out = IDLE_BIT; ser_valid = 0; word_done = 0.
  - Holding register empty; FSM in IDLE; bit counter = 0.
  - din_ready is forced 0 while rst_n is low.
  - A word in flight is discarded with no partial-word completion.
- Storage: holding register hold (DATA_W bits plus a full flag), shift register sreg, bit counter cnt of width clog2(DATA_W+1).
- Handshake:
  - Transfer occurs on an edge where din_valid && din_ready; din is written into hold.
  - din_ready = !hold_full || load_now, a combinational, same-cycle pass-through.
  - din may change freely when din_valid is low.
- load_now = hold_full && (state == IDLE || last_bit), where last_bit = (state == SHIFT && cnt == LEN-1).
  - LEN = DATA_W, or DATA_W+1 with parity enabled.
- FSM states:
  - IDLE: ser_out = IDLE_BIT, ser_valid = 0. If load_now: sreg <= hold, cnt <= 0, go to SHIFT.
  - SHIFT: each edge, ser_out <= the current bit (MSB or LSB per MSB_FIRST), ser_valid <= 1, sreg shifts, cnt increments.
    - On last_bit with load_now: reload sreg from hold and set cnt <= 0, staying in SHIFT (zero-bubble).
    - On last_bit without hold_full: return to IDLE.
- Latency:
  - Word accepted at edge N while IDLE: loaded at edge N+1; first bit valid on ser_out after edge N+2.
  - Last bit of word k is followed directly by the first bit of word k+1 when hold was full.
- Simultaneous accept and load: hold is read out and rewritten in the same edge; the old word goes to sreg and the new word to hold.
- Boundary behaviour:
  - hold full and shifter not on last bit: din_ready = 0; din_valid may stay high indefinitely without loss.
  - word_done asserts for exactly one cycle per word, on the cycle ser_out shows that word's final bit.
- busy = (state == SHIFT) || hold_full.
- No combinational path from din to ser_out.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the DATA_W data bits) is appended after each word's data bits; LEN = DATA_W+1.
  - ser_valid stays high during the parity bit; word_done moves to the parity cycle.
- Undefined: no parity bit, LEN = DATA_W, and no parity logic is instantiated.

Test Plan:
- Reset then single word: din = 8'h92, MSB_FIRST = 1, one-cycle valid -> ser_out = 1,0,0,1,0,0,1,0 on 8 consecutive cycles starting 2 cycles after accept; ser_valid high for exactly those 8 cycles; word_done high on the 8th; ser_out returns to 0.
- Back-to-back: din_valid held high with 8'h92 then 8'h49 -> 16 contiguous ser_valid cycles with no gap; second accept occurs while the first word shifts; two word_done pulses 8 cycles apart.
- Backpressure: three words offered continuously -> din_ready drops after hold fills and reasserts only on the last_bit cycle of the current word; no word lost or duplicated.
- LSB-first: MSB_FIRST = 0, din = 8'h01 -> ser_out sequence 1,0,0,0,0,0,0,0.
- Reset mid-word: rst_n low for 1 edge at the 4th bit of 8'hFF -> next cycle ser_out = IDLE_BIT, ser_valid = 0, busy = 0, no word_done; a subsequent word 8'h92 serializes correctly.
- SER_PARITY_EN defined: din = 8'h92 (three ones) -> 9 bits: 1,0,0,1,0,0,1,0,1; word_done on the 9th bit.
